// File: rtl/seq_mult_pkg.sv
// Shared types and elaboration helpers for the sequential array multiplier.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_e;

   // Number of RUN cycles for a full multiply; zero flags an illegal row count.
   function automatic int unsigned mult_cycles(input int unsigned width, input int unsigned rows);
      if (rows == 32'd0) begin
         return 32'd0;
      end else begin
         return width / rows;
      end
   endfunction

   // Bits needed to hold any value in 0 .. n-1.
   function automatic int unsigned cnt_bits(input int unsigned n);
      int unsigned bits;
      bits = 32'd1;
      while ((32'd1 << bits) < n) begin
         bits = bits + 32'd1;
      end
      return bits;
   endfunction

endpackage

// File: rtl/mult_row.sv
// One combinational row of the array: adds (or subtracts) the gated multiplicand
// to the incoming partial sum. SEQ_MULT_SIGNED_EN adds sign handling inputs.
module mult_row #(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic             b_bit_i,
   input  logic [WIDTH-1:0] s_in_i,
`ifdef SEQ_MULT_SIGNED_EN
   input  logic             sgn_i,
   input  logic             sub_i,
`endif
   output logic [WIDTH-1:0] s_out_o,
   output logic             c_out_o
);

   logic [WIDTH-1:0] pp_s;
   logic [WIDTH:0]   total_s;

`ifdef SEQ_MULT_SIGNED_EN
   logic [WIDTH:0]   s_ext_s;
   logic [WIDTH:0]   pp_ext_s;

   // In signed mode the carry bit acts as the sign of the widened partial sum.
   always_comb begin
      pp_s     = a_i & {WIDTH{b_bit_i}};
      s_ext_s  = {sgn_i & s_in_i[WIDTH-1], s_in_i};
      pp_ext_s = {sgn_i & pp_s[WIDTH-1], pp_s};
      if (sub_i) begin
         total_s = s_ext_s - pp_ext_s;
      end else begin
         total_s = s_ext_s + pp_ext_s;
      end
   end
`else
   // Unsigned row: plain add, the carry-out catches the overflow.
   always_comb begin
      pp_s    = a_i & {WIDTH{b_bit_i}};
      total_s = {1'b0, s_in_i} + {1'b0, pp_s};
   end
`endif

   assign s_out_o = total_s[WIDTH-1:0];
   assign c_out_o = total_s[WIDTH];

endmodule

// File: rtl/seq_array_multiplier.sv
// Sequential array multiplier: ROWS_PER_CYCLE rows per clock, start/done handshake.
// Optional two's-complement mode is enabled by defining SEQ_MULT_SIGNED_EN.
module seq_array_multiplier
   import seq_mult_pkg::*;
#(
   parameter int unsigned WIDTH          = 8,
   parameter int unsigned ROWS_PER_CYCLE = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
`ifdef SEQ_MULT_SIGNED_EN
   input  logic                 is_signed,
`endif
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned CYCLES = mult_cycles(WIDTH, ROWS_PER_CYCLE);
   localparam int unsigned CNT_W  = cnt_bits(WIDTH + 1);
   localparam logic [CNT_W-1:0] ROWS_C     = CNT_W'(ROWS_PER_CYCLE);
   localparam logic [CNT_W-1:0] WIDTH_C    = CNT_W'(WIDTH);
   localparam logic [CNT_W-1:0] LAST_ROW_C = CNT_W'(WIDTH - 1);

   if (WIDTH < 2 || CYCLES == 0 || CYCLES * ROWS_PER_CYCLE != WIDTH) begin : g_bad_cfg
      $error("seq_array_multiplier: WIDTH must be >= 2 and a multiple of ROWS_PER_CYCLE");
   end

   mult_state_e          state_q, state_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic [WIDTH-1:0]     a_q, a_d;
   logic [WIDTH-1:0]     b_q, b_d;
   logic [WIDTH-1:0]     sum_q, sum_d;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   product_q, product_d;
`ifdef SEQ_MULT_SIGNED_EN
   logic                 sgn_q, sgn_d;
`endif

   logic [ROWS_PER_CYCLE:0][WIDTH-1:0] chain_s;
   logic [ROWS_PER_CYCLE-1:0]          lsb_s;
   logic [ROWS_PER_CYCLE+WIDTH-1:0]    lo_cat_s;
   logic [WIDTH-1:0]                   lo_next_s;

   assign chain_s[0] = sum_q;

   for (genvar i = 0; i < ROWS_PER_CYCLE; i++) begin : g_row
      logic [WIDTH-1:0] s_out_s;
      logic             c_out_s;
`ifdef SEQ_MULT_SIGNED_EN
      logic             sub_s;
      // Only the row carrying the multiplier MSB has negative weight.
      assign sub_s = sgn_q & ((cnt_q + CNT_W'(i)) == LAST_ROW_C);
`endif
      mult_row #(
         .WIDTH   (WIDTH)
      ) u_row (
         .a_i     (a_q),
         .b_bit_i (b_q[i]),
         .s_in_i  (chain_s[i]),
`ifdef SEQ_MULT_SIGNED_EN
         .sgn_i   (sgn_q),
         .sub_i   (sub_s),
`endif
         .s_out_o (s_out_s),
         .c_out_o (c_out_s)
      );
      assign chain_s[i+1] = {c_out_s, s_out_s[WIDTH-1:1]};
      assign lsb_s[i]     = s_out_s[0];
   end

   // Row LSBs retire into the low half, earliest row ending up lowest.
   assign lo_cat_s  = {lsb_s, lo_q};
   assign lo_next_s = lo_cat_s[ROWS_PER_CYCLE +: WIDTH];

   // Next-state and datapath control.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      lo_d      = lo_q;
      cnt_d     = cnt_q;
      product_d = product_q;
`ifdef SEQ_MULT_SIGNED_EN
      sgn_d     = sgn_q;
`endif
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               sum_d   = '0;
               lo_d    = '0;
               cnt_d   = '0;
`ifdef SEQ_MULT_SIGNED_EN
               sgn_d   = is_signed;
`endif
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            sum_d = chain_s[ROWS_PER_CYCLE];
            lo_d  = lo_next_s;
            b_d   = b_q >> ROWS_PER_CYCLE;
            cnt_d = cnt_q + ROWS_C;
            if ((cnt_q + ROWS_C) == WIDTH_C) begin
               product_d = {chain_s[ROWS_PER_CYCLE], lo_next_s};
               state_d   = DONE;
            end else begin
               state_d   = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         sum_q     <= '0;
         lo_q      <= '0;
         cnt_q     <= '0;
         product_q <= '0;
`ifdef SEQ_MULT_SIGNED_EN
         sgn_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         a_q       <= a_d;
         b_q       <= b_d;
         sum_q     <= sum_d;
         lo_q      <= lo_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
`ifdef SEQ_MULT_SIGNED_EN
         sgn_q     <= sgn_d;
`endif
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule

// File: tb/tb_seq_array_multiplier.sv
// Directed bench for seq_array_multiplier: one instance per row count (1 and 2).
module tb_seq_array_multiplier;

   logic        clk;
   logic        rst_n;
   logic        start1, start2;
   logic [7:0]  a1, b1, a2, b2;
   logic        sgn1, sgn2;
   logic        busy1, done1, busy2, done2;
   logic [15:0] prod1, prod2;

   int n_checks;
   int n_fail;

   seq_array_multiplier #(.WIDTH(8), .ROWS_PER_CYCLE(1)) dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start1),
      .a         (a1),
      .b         (b1),
`ifdef SEQ_MULT_SIGNED_EN
      .is_signed (sgn1),
`endif
      .busy      (busy1),
      .done      (done1),
      .product   (prod1)
   );

   seq_array_multiplier #(.WIDTH(8), .ROWS_PER_CYCLE(2)) dut2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start2),
      .a         (a2),
      .b         (b2),
`ifdef SEQ_MULT_SIGNED_EN
      .is_signed (sgn2),
`endif
      .busy      (busy2),
      .done      (done2),
      .product   (prod2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (obs !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Starts a multiply on dut1, checks busy through RUN, latency 9, result and pulse width.
   task automatic mult1(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                        input logic [15:0] exp, input string tag);
      int cyc;
      @(negedge clk);
      start1 = 1'b1; a1 = av; b1 = bv; sgn1 = sv;
      @(negedge clk);
      start1 = 1'b0;
      cyc = 1;
      while (!done1 && cyc < 20) begin
         check_eq({tag, "_busy"}, 32'(busy1), 32'd1);
         @(negedge clk);
         cyc = cyc + 1;
      end
      check_eq({tag, "_lat"}, 32'(cyc), 32'd9);
      check_eq({tag, "_prod"}, 32'(prod1), 32'(exp));
      check_eq({tag, "_busy_dn"}, 32'(busy1), 32'd0);
      @(negedge clk);
      check_eq({tag, "_pulse"}, 32'(done1), 32'd0);
      check_eq({tag, "_hold"}, 32'(prod1), 32'(exp));
   endtask

   initial begin
      int cyc;
      int extra;
      n_checks = 0;
      n_fail   = 0;
      rst_n  = 1'b0;
      start1 = 1'b0; a1 = 8'd0; b1 = 8'd0; sgn1 = 1'b0;
      start2 = 1'b0; a2 = 8'd0; b2 = 8'd0; sgn2 = 1'b0;
      #12;
      check_eq("rst_busy", 32'(busy1), 32'd0);
      check_eq("rst_done", 32'(done1), 32'd0);
      check_eq("rst_prod", 32'(prod1), 32'd0);
      check_eq("rst_prod2", 32'(prod2), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      mult1(8'd13,  8'd11,  1'b0, 16'h008F, "m13x11");
      mult1(8'd255, 8'd255, 1'b0, 16'hFE01, "m255x255");
      mult1(8'd0,   8'd200, 1'b0, 16'h0000, "m0x200");
      mult1(8'd1,   8'd1,   1'b0, 16'h0001, "m1x1");

      // Start during RUN must be ignored.
      @(negedge clk);
      start1 = 1'b1; a1 = 8'd13; b1 = 8'd11;
      @(negedge clk);
      start1 = 1'b0;
      cyc = 1;
      extra = 0;
      while (!done1 && cyc < 20) begin
         if (cyc == 3) begin
            start1 = 1'b1; a1 = 8'd7; b1 = 8'd7;
         end else begin
            start1 = 1'b0;
         end
         @(negedge clk);
         cyc = cyc + 1;
      end
      start1 = 1'b0;
      check_eq("ign_lat", 32'(cyc), 32'd9);
      check_eq("ign_prod", 32'(prod1), 32'h008F);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done1) extra = extra + 1;
      end
      check_eq("ign_no_extra_done", 32'(extra), 32'd0);
      check_eq("ign_hold", 32'(prod1), 32'h008F);

      // Asynchronous reset in the middle of RUN.
      @(negedge clk);
      start1 = 1'b1; a1 = 8'd255; b1 = 8'd255;
      @(negedge clk);
      start1 = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_busy", 32'(busy1), 32'd0);
      check_eq("midrst_prod", 32'(prod1), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      extra = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (done1) extra = extra + 1;
      end
      check_eq("midrst_no_done", 32'(extra), 32'd0);
      mult1(8'd200, 8'd3, 1'b0, 16'd600, "m_after_rst");

      // Two rows per cycle, start held high through DONE for back-to-back results.
      @(negedge clk);
      start2 = 1'b1; a2 = 8'd100; b2 = 8'd200;
      @(negedge clk);
      a2 = 8'd55; b2 = 8'd3;
      cyc = 1;
      while (!done2 && cyc < 20) begin
         @(negedge clk);
         cyc = cyc + 1;
      end
      check_eq("r2_lat", 32'(cyc), 32'd5);
      check_eq("r2_prod", 32'(prod2), 32'd20000);
      @(negedge clk);
      start2 = 1'b0;
      cyc = cyc + 1;
      check_eq("r2_b2b_busy", 32'(busy2), 32'd1);
      while (!done2 && cyc < 30) begin
         @(negedge clk);
         cyc = cyc + 1;
      end
      check_eq("r2_b2b_lat", 32'(cyc), 32'd10);
      check_eq("r2_b2b_prod", 32'(prod2), 32'd165);
      @(negedge clk);
      check_eq("r2_idle", 32'(busy2), 32'd0);

`ifdef SEQ_MULT_SIGNED_EN
      mult1(8'hFD, 8'd5,  1'b1, 16'hFFF1, "s_m3x5");
      mult1(8'h80, 8'h80, 1'b1, 16'h4000, "s_m128sq");
      mult1(8'hFD, 8'd5,  1'b0, 16'h04F1, "u_253x5");
      mult1(8'h80, 8'h80, 1'b0, 16'h4000, "u_128sq");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
